w0rm_alu_issue: RTL and testbench
=================================

Name: w0rm_alu_issue

Overview:
Execute-stage sequencer that sits directly upstream of the W0RM core ALU and feeds it. It accepts one decoded instruction at a time and reads operands from the register file. It issues a single-cycle data_valid pulse to the ALU, waits for result_valid, then writes the result back to the register file. A watchdog aborts an operation if the ALU never answers, for example a hung divide.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the ALU
REG_ADDR_WIDTH, 4, register file address width (16 registers)
TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort; legal range 2..65535

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  decoder presents an instruction
instr_ready  out  1  high only in IDLE
instr_opcode  in  4  ALU opcode
instr_dst  in  REG_ADDR_WIDTH  destination register
instr_src_a  in  REG_ADDR_WIDTH  source A register
instr_src_b  in  REG_ADDR_WIDTH  source B register
instr_use_imm  in  1  1: operand B = instr_imm
instr_imm  in  DATA_WIDTH  immediate
instr_flags_mask  in  4  flag store mask {C,V,N,Z}
instr_ext_16  in  1  extend size, 1 = 16-bit
rf_rd_a_addr  out  REG_ADDR_WIDTH  read port A address
rf_rd_a_data  in  DATA_WIDTH  read port A data (combinational RF read)
rf_rd_b_addr  out  REG_ADDR_WIDTH  read port B address
rf_rd_b_data  in  DATA_WIDTH  read port B data
rf_wr_en  out  1  write strobe
rf_wr_addr  out  REG_ADDR_WIDTH  write address
rf_wr_data  out  DATA_WIDTH  write data
alu_opcode  out  4  to ALU opcode
alu_data_valid  out  1  one-cycle issue pulse
alu_store_flags_mask  out  4  to ALU store_flags_mask
alu_ext_bit_size  out  1  to ALU ext_bit_size
alu_data_a  out  DATA_WIDTH  operand A
alu_data_b  out  DATA_WIDTH  operand B
alu_result  in  DATA_WIDTH  ALU result
alu_result_valid  in  1  ALU result valid
done  out  1  one-cycle pulse per retired instruction
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- One clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values: state = IDLE, all latched fields = 0, operand registers = 0, counter = 0. Outputs: instr_ready = 1; rf_wr_en, alu_data_valid, done and timeout_err = 0; all data, address and mask outputs = 0.
- FSM states: IDLE, READ, ISSUE, WAIT, WB.
- IDLE: instr_ready = 1. When instr_valid = 1, latch opcode, dst, src_a, src_b, use_imm, imm, flags_mask and ext_16, then go to READ.
- READ: rf_rd_*_addr are driven from the latched src fields. At the clock edge, capture alu_data_a = rf_rd_a_data and alu_data_b = use_imm ? imm : rf_rd_b_data. Go to ISSUE.
- ISSUE: alu_data_valid = 1 for exactly this cycle. Go to WAIT and clear the counter.
- Held stable from ISSUE until the block leaves WAIT: alu_opcode, alu_data_a/b, alu_store_flags_mask and alu_ext_bit_size. The ALU samples the mask and size at result time.
- WAIT: alu_result_valid is honoured only in this state; it is ignored in every other state, including a stale pulse from an earlier operation.
  - On alu_result_valid = 1: register alu_result, go to WB.
  - Otherwise increment the counter. When the counter equals TIMEOUT_CYCLES-1 and alu_result_valid = 0: pulse timeout_err, perform no writeback, go to IDLE.
- WB: rf_wr_en = 1, rf_wr_addr = dst, rf_wr_data = captured result, done = 1, each for exactly one cycle. Go to IDLE.
- All opcodes write back, including MOV (0xF), which returns operand B.
- Minimum latency from instr_valid accept to done is 4 cycles plus the ALU latency. Maximum throughput is one instruction per 5 cycles.
- A write in WB is visible to a READ of the following instruction. The register file has a synchronous write and a combinational read, so no forwarding is required.
- If alu_result_valid arrives on the same cycle the counter hits its limit, the result wins: go to WB, no timeout_err.
- Reset in any state forces IDLE on the next edge and suppresses any pending writeback or done. The ALU has no reset, so its pending operation may swallow the next issue; the watchdog recovers this case, and the bench must tolerate one timeout_err after a mid-WAIT reset.
- instr_* inputs are don't-care outside IDLE.

Optional Feature:
W0RM_ALU_ISSUE_PERF_EN
- Defined: adds output ports perf_retired[31:0] (increments on each done) and perf_stall[31:0] (increments on each WAIT cycle). Both saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- ADD: R1 = 0x05, R2 = 0x03, instr ADD dst = R4, ALU returns 0x08 two cycles after issue -> one alu_data_valid pulse with a = 0x05, b = 0x03; rf_wr_en with addr = 4, data = 0x08; done pulse.
- MOV immediate: use_imm = 1, imm = 0xA5, dst = R7 -> alu_data_b = 0xA5 regardless of R(src_b); R7 written 0xA5; flags_mask held stable until the result.
- Back-to-back: ADD R3 = R1 + R2 then SUB R5 = R3 - R1 -> second READ sees the new R3; instr_ready low for the entire first operation.
- Watchdog: TIMEOUT_CYCLES = 8, ALU never asserts result_valid -> timeout_err pulse 8 cycles after entering WAIT; no rf_wr_en; instr_ready = 1 next cycle; a late result_valid is ignored.
- Boundary: result_valid on the exact timeout cycle -> WB, no timeout_err. A stray result_valid while in IDLE or READ -> no write.
- Reset asserted mid-WAIT -> next cycle IDLE with all outputs at reset values; no done; the following instruction completes (at most one timeout). With PERF_EN: both counters read 0 after reset and perf_retired = 1 after the following instruction completes.

Source files
------------

// File: rtl/w0rm_alu_issue.sv
// Execute-stage sequencer feeding the W0RM ALU: IDLE -> READ -> ISSUE -> WAIT -> WB, with a watchdog on WAIT.
// Optional build macro W0RM_ALU_ISSUE_PERF_EN adds saturating retired/stall performance counters.
module w0rm_alu_issue #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [3:0]                instr_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] instr_dst,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src_a,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src_b,
  input  logic                      instr_use_imm,
  input  logic [DATA_WIDTH-1:0]     instr_imm,
  input  logic [3:0]                instr_flags_mask,
  input  logic                      instr_ext_16,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_a_addr,
  input  logic [DATA_WIDTH-1:0]     rf_rd_a_data,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_b_addr,
  input  logic [DATA_WIDTH-1:0]     rf_rd_b_data,
  output logic                      rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0]     rf_wr_data,
  output logic [3:0]                alu_opcode,
  output logic                      alu_data_valid,
  output logic [3:0]                alu_store_flags_mask,
  output logic                      alu_ext_bit_size,
  output logic [DATA_WIDTH-1:0]     alu_data_a,
  output logic [DATA_WIDTH-1:0]     alu_data_b,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_result_valid,
  output logic                      done,
  output logic                      timeout_err
`ifdef W0RM_ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]               perf_retired,
  output logic [31:0]               perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                    state;
  logic [15:0]               cnt;
  logic                      tout;

  logic [3:0]                opcode_p0;
  logic [REG_ADDR_WIDTH-1:0] dst_p0;
  logic [REG_ADDR_WIDTH-1:0] src_a_p0;
  logic [REG_ADDR_WIDTH-1:0] src_b_p0;
  logic                      use_imm_p0;
  logic [DATA_WIDTH-1:0]     imm_p0;
  logic [3:0]                mask_p0;
  logic                      ext_p0;
  logic [DATA_WIDTH-1:0]     opa_p1;
  logic [DATA_WIDTH-1:0]     opb_p1;
  logic [DATA_WIDTH-1:0]     result_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tout       <= 1'b0;
      opcode_p0  <= '0;
      dst_p0     <= '0;
      src_a_p0   <= '0;
      src_b_p0   <= '0;
      use_imm_p0 <= 1'b0;
      imm_p0     <= '0;
      mask_p0    <= '0;
      ext_p0     <= 1'b0;
      opa_p1     <= '0;
      opb_p1     <= '0;
      result_p2  <= '0;
    end else begin
      tout <= 1'b0;
      unique case (state)
        // p0: latch the decoded instruction
        S_IDLE: begin
          if (instr_valid) begin
            opcode_p0  <= instr_opcode;
            dst_p0     <= instr_dst;
            src_a_p0   <= instr_src_a;
            src_b_p0   <= instr_src_b;
            use_imm_p0 <= instr_use_imm;
            imm_p0     <= instr_imm;
            mask_p0    <= instr_flags_mask;
            ext_p0     <= instr_ext_16;
            state      <= S_READ;
          end
        end
        // p1: capture operands from the combinational register-file read
        S_READ: begin
          opa_p1 <= rf_rd_a_data;
          opb_p1 <= use_imm_p0 ? imm_p0 : rf_rd_b_data;
          state  <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        // p2: result capture; a result on the final watchdog cycle still wins
        S_WAIT: begin
          if (alu_result_valid) begin
            result_p2 <= alu_result;
            state     <= S_WB;
          end else if (cnt == CNT_LAST) begin
            tout  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready          = (state == S_IDLE);
  assign rf_rd_a_addr         = src_a_p0;
  assign rf_rd_b_addr         = src_b_p0;
  assign alu_data_valid       = (state == S_ISSUE);
  assign alu_opcode           = opcode_p0;
  assign alu_store_flags_mask = mask_p0;
  assign alu_ext_bit_size     = ext_p0;
  assign alu_data_a           = opa_p1;
  assign alu_data_b           = opb_p1;
  assign rf_wr_en             = (state == S_WB);
  assign rf_wr_addr           = dst_p0;
  assign rf_wr_data           = result_p2;
  assign done                 = (state == S_WB);
  assign timeout_err          = tout;

`ifdef W0RM_ALU_ISSUE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (state == S_WB)   perf_retired <= sat_inc(perf_retired);
      if (state == S_WAIT) perf_stall   <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_w0rm_alu_issue.sv
// Scoreboard bench for w0rm_alu_issue: behavioural register file and ALU, expected writes queued at drive time.
module tb_w0rm_alu_issue;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_opcode;
  logic [3:0] instr_dst, instr_src_a, instr_src_b;
  logic       instr_use_imm;
  logic [7:0] instr_imm;
  logic [3:0] instr_flags_mask;
  logic       instr_ext_16;
  logic [3:0] rf_rd_a_addr, rf_rd_b_addr, rf_wr_addr;
  logic [7:0] rf_rd_a_data, rf_rd_b_data, rf_wr_data;
  logic       rf_wr_en;
  logic [3:0] alu_opcode, alu_store_flags_mask;
  logic       alu_data_valid, alu_ext_bit_size;
  logic [7:0] alu_data_a, alu_data_b, alu_result;
  logic       alu_result_valid;
  logic       done, timeout_err;
`ifdef W0RM_ALU_ISSUE_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  w0rm_alu_issue #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_dst(instr_dst), .instr_src_a(instr_src_a), .instr_src_b(instr_src_b),
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
    .instr_flags_mask(instr_flags_mask), .instr_ext_16(instr_ext_16),
    .rf_rd_a_addr(rf_rd_a_addr), .rf_rd_a_data(rf_rd_a_data),
    .rf_rd_b_addr(rf_rd_b_addr), .rf_rd_b_data(rf_rd_b_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_opcode(alu_opcode), .alu_data_valid(alu_data_valid),
    .alu_store_flags_mask(alu_store_flags_mask), .alu_ext_bit_size(alu_ext_bit_size),
    .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid),
    .done(done), .timeout_err(timeout_err)
`ifdef W0RM_ALU_ISSUE_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'hF:    return b;
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] rf_init(input int i);
    if (i == 1) return 8'h05;
    if (i == 2) return 8'h03;
    return 8'(i * 17);
  endfunction

  // Register file: synchronous write, combinational read; loaded once on the first clock.
  logic [7:0] rf [16];
  logic [7:0] sh [16];
  bit         rf_loaded;
  assign rf_rd_a_data = rf[rf_rd_a_addr];
  assign rf_rd_b_data = rf[rf_rd_b_addr];
  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 16; i++) rf[i] <= rf_init(i);
      rf_loaded <= 1'b1;
    end else if (rf_wr_en) begin
      rf[rf_wr_addr] <= rf_wr_data;
    end
  end

  // ALU model: result_valid appears alu_lat cycles after the ISSUE cycle; never when hung. No reset.
  int         alu_lat = 2;
  logic       alu_hang = 1'b0;
  logic       stray = 1'b0;
  logic       rv_model = 1'b0;
  int         cd = 0;
  logic [7:0] res_m = 8'h00;
  assign alu_result       = res_m;
  assign alu_result_valid = rv_model | stray;
  always @(posedge clk) begin
    rv_model <= 1'b0;
    if (alu_data_valid) begin
      res_m <= alu_fn(alu_opcode, alu_data_a, alu_data_b);
      if (alu_hang)          cd <= 0;
      else if (alu_lat <= 1) rv_model <= 1'b1;
      else                   cd <= alu_lat - 1;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) rv_model <= 1'b1;
    end
  end

  // Scoreboards: issue fields {op,mask,ext,a,b} and writebacks {addr,data}
  logic [24:0] opq[$];
  logic [11:0] wrq[$];
  logic [24:0] iss;
  logic        op_live = 1'b0;
  logic        dv_prev = 1'b0;

  always @(negedge clk) begin
    logic [24:0] e;
    logic [11:0] w;
    if (reset) begin
      op_live = 1'b0;
    end else begin
      if (alu_data_valid) begin
        chk_eq("dv_single_cycle", {31'd0, dv_prev}, 32'd0);
        if (opq.size() == 0) chk_eq("dv_unexpected", 32'd1, 32'd0);
        else begin
          e = opq.pop_front();
          chk_eq("issue_op",   {28'd0, alu_opcode}, {28'd0, e[24:21]});
          chk_eq("issue_mask", {28'd0, alu_store_flags_mask}, {28'd0, e[20:17]});
          chk_eq("issue_ext",  {31'd0, alu_ext_bit_size}, {31'd0, e[16]});
          chk_eq("issue_a",    {24'd0, alu_data_a}, {24'd0, e[15:8]});
          chk_eq("issue_b",    {24'd0, alu_data_b}, {24'd0, e[7:0]});
          iss     = e;
          op_live = 1'b1;
        end
      end
      if (rv_model && op_live) begin
        chk_eq("hold_fields", {7'd0, alu_opcode, alu_store_flags_mask, alu_ext_bit_size,
                               alu_data_a, alu_data_b}, {7'd0, iss});
      end
      if (done && !rf_wr_en) chk_eq("done_without_wr", 32'd1, 32'd0);
      if (rf_wr_en) begin
        chk_eq("done_with_wr", {31'd0, done}, 32'd1);
        if (wrq.size() == 0) chk_eq("wr_unexpected", {20'd0, rf_wr_addr, rf_wr_data}, 32'hFFFF_FFFF);
        else begin
          w = wrq.pop_front();
          chk_eq("wr_addr", {28'd0, rf_wr_addr}, {28'd0, w[11:8]});
          chk_eq("wr_data", {24'd0, rf_wr_data}, {24'd0, w[7:0]});
        end
        op_live = 1'b0;
      end
      if (timeout_err) op_live = 1'b0;
    end
    dv_prev = alu_data_valid;
  end

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    chk_eq({tag, "_strobes"}, {28'd0, rf_wr_en, alu_data_valid, done, timeout_err}, 32'd0);
    chk_eq({tag, "_data"}, {alu_data_a, alu_data_b, rf_wr_data, 8'd0}, 32'd0);
    chk_eq({tag, "_addr_mask"}, {8'd0, rf_wr_addr, rf_rd_a_addr, rf_rd_b_addr, alu_opcode,
                                 alu_store_flags_mask, 3'd0, alu_ext_bit_size}, 32'd0);
  endtask

  // Drive one instruction and follow it to done / timeout / a reset injected at WAIT cycle 1.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] sa,
                           input logic [3:0] sb, input logic ui, input logic [7:0] imm,
                           input logic [3:0] mask, input logic ext, input int lat,
                           input logic hang, input logic stray_read, input logic rst_mid);
    logic [7:0] a, b, r;
    int k;
    logic got;
    a = sh[sa];
    b = ui ? imm : sh[sb];
    r = alu_fn(op, a, b);
    opq.push_back({op, mask, ext, a, b});
    if (!hang && !rst_mid) begin
      wrq.push_back({dst, r});
      sh[dst] = r;
    end
    alu_lat  = lat;
    alu_hang = hang;
    @(posedge clk); #1;
    chk_eq("ready_idle", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1; instr_opcode = op; instr_dst = dst; instr_src_a = sa; instr_src_b = sb;
    instr_use_imm = ui; instr_imm = imm; instr_flags_mask = mask; instr_ext_16 = ext;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr_opcode = 4'($urandom); instr_dst = 4'($urandom);
    instr_src_a = 4'($urandom); instr_src_b = 4'($urandom); instr_use_imm = 1'($urandom);
    instr_imm = 8'($urandom); instr_flags_mask = 4'($urandom); instr_ext_16 = 1'($urandom);
    k = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) stray = stray_read;
      if (k == 2) stray = 1'b0;
      if (rst_mid && k == 4) begin
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rst_mid");
`ifdef W0RM_ALU_ISSUE_PERF_EN
        chk_eq("perf_retired_rst", perf_retired, 32'd0);
        chk_eq("perf_stall_rst", perf_stall, 32'd0);
`endif
        @(posedge clk); #1 reset = 1'b0;
        return;
      end
      if (done || timeout_err) got = 1'b1;
      else chk_eq("ready_busy", {31'd0, instr_ready}, 32'd0);
    end
    chk_eq("completed", {31'd0, got}, 32'd1);
    chk_eq("timeout_flag", {31'd0, timeout_err}, {31'd0, hang});
    chk_eq("latency", k, hang ? 3 + TMO : 3 + lat);
    if (hang) chk_eq("ready_after_tmo", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic stray_idle(input string tag);
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_eq(tag, {30'd0, rf_wr_en, done}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sh[i] = rf_init(i);
    reset = 1'b1; instr_valid = 1'b0; instr_opcode = '0; instr_dst = '0; instr_src_a = '0;
    instr_src_b = '0; instr_use_imm = 1'b0; instr_imm = '0; instr_flags_mask = '0; instr_ext_16 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
`ifdef W0RM_ALU_ISSUE_PERF_EN
    chk_eq("perf_zero", perf_retired | perf_stall, 32'd0);
`endif

    // ADD R4 = R1 + R2 -> 0x08
    run_instr(4'h0, 4'd4, 4'd1, 4'd2, 1'b0, 8'h00, 4'b0011, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    // MOV R7 = #0xA5, src_b ignored, mask and size held until the result
    run_instr(4'hF, 4'd7, 4'd1, 4'd2, 1'b1, 8'hA5, 4'b1010, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    // Back-to-back dependency through R3
    run_instr(4'h0, 4'd3, 4'd1, 4'd2, 1'b0, 8'h00, 4'b1111, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run_instr(4'h1, 4'd5, 4'd3, 4'd1, 1'b0, 8'h00, 4'b0001, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    // Result on the last watchdog cycle wins
    run_instr(4'h4, 4'd6, 4'd4, 4'd7, 1'b0, 8'h00, 4'b0100, 1'b1, TMO, 1'b0, 1'b0, 1'b0);
    // Hung ALU: timeout, no writeback, late result ignored
    run_instr(4'h2, 4'd9, 4'd7, 4'd5, 1'b0, 8'h00, 4'b0000, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    stray_idle("late_result_idle");
    // Stray result while IDLE, then during READ of a normal op
    stray_idle("stray_idle");
    run_instr(4'h3, 4'd10, 4'd5, 4'd6, 1'b0, 8'h00, 4'b0110, 1'b0, 3, 1'b0, 1'b1, 1'b0);
    // Reset during WAIT, then the next instruction must still retire
    run_instr(4'h0, 4'd8, 4'd1, 4'd2, 1'b0, 8'h00, 4'b1000, 1'b0, 6, 1'b0, 1'b0, 1'b1);
    run_instr(4'h0, 4'd11, 4'd4, 4'd7, 1'b0, 8'h00, 4'b0001, 1'b0, 2, 1'b0, 1'b0, 1'b0);
`ifdef W0RM_ALU_ISSUE_PERF_EN
    chk_eq("perf_retired_after", perf_retired, 32'd1);
    chk_eq("perf_stall_after", perf_stall, 32'd2);
`endif

    repeat (4) @(negedge clk);
    chk_eq("wrq_drained", wrq.size(), 32'd0);
    chk_eq("opq_drained", opq.size(), 32'd0);
    chk_eq("rf_r4", {24'd0, rf[4]}, 32'h08);
    chk_eq("rf_r7", {24'd0, rf[7]}, 32'hA5);
    chk_eq("rf_r5", {24'd0, rf[5]}, 32'h03);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0, want 0x1");
    $fatal(1, "bench did not finish");
  end

endmodule
